seq_divider_8bit: RTL
=====================

SEQ_DIVIDER_8BIT -- requirements
Module: seq_divider_8bit

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, setting the divisor, quotient and remainder width; the dividend is 2*DATA_WIDTH bits.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 inStart  input  1  request pulse; sampled only in IDLE or DONE.
REQ-005 inData_A  input  2*DATA_WIDTH  dividend, e.g. a 16-bit multiplier product.
REQ-006 inData_B  input  DATA_WIDTH  divisor.
REQ-007 outData_Q  output  DATA_WIDTH  quotient, registered.
REQ-008 outData_R  output  DATA_WIDTH  remainder, registered.
REQ-009 outBusy  output  1  high while a division is in progress.
REQ-010 outValid  output  1  one-cycle pulse marking new outData_Q/outData_R.
REQ-011 outError  output  1  error flag, valid with outValid; it exists only when DIV_OVERFLOW_CHECK_EN is defined (REQ-028).

Function
REQ-012 The FSM SHALL have three states, IDLE, RUN and DONE, with these transitions:
- IDLE/DONE -> RUN when inStart=1.
- IDLE/DONE -> IDLE when inStart=0.
- RUN -> DONE after the last iteration.
REQ-013 On the accepting edge (t0) the block SHALL capture inData_A and inData_B, clear the partial remainder and the iteration counter, and set outBusy=1.
REQ-014 The RUN state SHALL perform unsigned restoring division at one dividend bit per clock, MSB first, for 2*DATA_WIDTH iterations (edges t1..t16 for DATA_WIDTH=8).
- Each iteration: shift the partial remainder left and bring in the next dividend bit.
- Trial-subtract the divisor using a DATA_WIDTH+1-bit difference.
- If the difference is non-negative, keep it and set the quotient bit; otherwise restore the remainder and clear the quotient bit.
REQ-015 At edge t16 the block SHALL load outData_Q with the low DATA_WIDTH bits of the full quotient and outData_R with the exact remainder, set outValid=1, set outBusy=0, and enter DONE.
REQ-016 outValid SHALL be high for exactly one cycle, the cycle between t16 and t17.
REQ-017 outData_Q and outData_R SHALL hold their values until the next result is loaded.
REQ-018 inStart during RUN SHALL be ignored; it is neither queued nor allowed to disturb the operands.
REQ-019 inStart in DONE SHALL start a new division on that edge, giving a back-to-back throughput of one result per 17 cycles.
REQ-020 The operand registers SHALL be insensitive to input changes after t0.
REQ-021 With divisor 0 and DIV_OVERFLOW_CHECK_EN undefined, the normal 16-iteration run SHALL complete and produce outData_Q = all ones and outData_R = inData_A[DATA_WIDTH-1:0].

Reset
REQ-022 When rst=1, the block SHALL go immediately (asynchronously) to IDLE with outData_Q=0, outData_R=0, outBusy=0, outValid=0, outError=0, and the counter, operands and partial remainder cleared.
REQ-023 Reset asserted during RUN SHALL abort the division with no outValid pulse.
REQ-024 After rst deasserts, the first rising edge with inStart=1 SHALL start a new division.

Configuration
REQ-025 The macro DIV_OVERFLOW_CHECK_EN SHALL control operand checking.
REQ-026 When DIV_OVERFLOW_CHECK_EN is defined, at t0 the block SHALL flag an error if inData_B==0 or inData_A[2*DATA_WIDTH-1:DATA_WIDTH] >= inData_B (quotient does not fit in DATA_WIDTH bits).
REQ-027 On a flagged error the FSM SHALL go straight to DONE at t0 with outValid=1, outError=1, outData_Q = all ones, outData_R=0, and outBusy kept at 0 throughout.
REQ-028 When DIV_OVERFLOW_CHECK_EN is defined, outError SHALL be 0 on every non-error result; when it is undefined, the outError port SHALL not exist and results SHALL follow REQ-014/REQ-021 (quotient truncated to its low bits).

Verification
REQ-029 Basic division: 0x00F0 / 0x0C, inStart at t0 -> outBusy for 16 cycles, then outValid pulse with Q=0x14, R=0x00.
REQ-030 Non-trivial remainder: 0x3039 / 0x71 -> Q=0x6D, R=0x1C, outValid exactly 16 edges after t0.
REQ-031 Overflow: 0xFFFF / 0x01 -> with the macro, outValid and outError at t0 with Q=0xFF, R=0x00; without the macro, Q=0xFF, R=0x00 after 16 cycles.
REQ-032 Divide by zero: 0x1234 / 0x00 -> with the macro, outError=1, Q=0xFF, R=0x00; without the macro, Q=0xFF, R=0x34.
REQ-033 Start during RUN: a second inStart at t5 with different operands -> ignored, and the first result is unchanged.
REQ-034 Reset mid-operation: rst at t8 -> all outputs 0 immediately, no outValid; a following 0x0064 / 0x07 gives Q=0x0E, R=0x02.

Source files
------------

// File: rtl/seq_divider_8bit.sv
// Unsigned restoring divider: 2*DATA_WIDTH-bit dividend / DATA_WIDTH-bit divisor, one dividend bit per clock.
// Latency: result 2*DATA_WIDTH edges after the accepting edge; no backpressure, inStart ignored while busy.
// Optional operand checking (divide-by-zero / quotient overflow) enabled by DIV_OVERFLOW_CHECK_EN.
module seq_divider_8bit #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      inStart,
    input  logic [2*DATA_WIDTH-1:0]   inData_A,
    input  logic [DATA_WIDTH-1:0]     inData_B,
    output logic [DATA_WIDTH-1:0]     outData_Q,
    output logic [DATA_WIDTH-1:0]     outData_R,
    output logic                      outBusy,
    output logic                      outValid
`ifdef DIV_OVERFLOW_CHECK_EN
    ,
    output logic                      outError
`endif
);

    localparam int CW = $clog2(2*DATA_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(2*DATA_WIDTH-1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                    state, next_state;
    logic [2*DATA_WIDTH-1:0]   dvd;
    logic [DATA_WIDTH-1:0]     div;
    logic [DATA_WIDTH-1:0]     rem;
    logic [CW-1:0]             cnt;

    logic [DATA_WIDTH:0]       shifted;
    logic [DATA_WIDTH-1:0]     diff;
    logic                      ge;
    logic [DATA_WIDTH-1:0]     rem_next;
    logic [2*DATA_WIDTH-1:0]   dvd_next;
    logic                      last_iter;
    logic                      op_err;

    // The dividend register doubles as the quotient: bits shift out the top
    // into the remainder while quotient bits shift in at the bottom.
    assign shifted  = {rem, dvd[2*DATA_WIDTH-1]};
    assign ge       = shifted >= {1'b0, div};
    // Whenever the difference is kept it fits DATA_WIDTH bits, so the low bits suffice.
    assign diff     = shifted[DATA_WIDTH-1:0] - div;
    assign rem_next = ge ? diff : shifted[DATA_WIDTH-1:0];
    assign dvd_next = {dvd[2*DATA_WIDTH-2:0], ge};
    assign last_iter = (state == RUN) && (cnt == LAST);

`ifdef DIV_OVERFLOW_CHECK_EN
    assign op_err = (inData_B == '0) || (inData_A[2*DATA_WIDTH-1:DATA_WIDTH] >= inData_B);
`else
    assign op_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: begin
                if (inStart) next_state = op_err ? DONE : RUN;
                else         next_state = IDLE;
            end
            RUN:     if (last_iter) next_state = DONE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dvd       <= '0;
            div       <= '0;
            rem       <= '0;
            cnt       <= '0;
            outData_Q <= '0;
            outData_R <= '0;
            outBusy   <= 1'b0;
            outValid  <= 1'b0;
`ifdef DIV_OVERFLOW_CHECK_EN
            outError  <= 1'b0;
`endif
        end else begin
            outValid <= 1'b0;
`ifdef DIV_OVERFLOW_CHECK_EN
            outError <= 1'b0;
`endif
            case (state)
                IDLE, DONE: begin
                    if (inStart) begin
                        if (op_err) begin
                            outData_Q <= '1;
                            outData_R <= '0;
                            outValid  <= 1'b1;
`ifdef DIV_OVERFLOW_CHECK_EN
                            outError  <= 1'b1;
`endif
                        end else begin
                            dvd     <= inData_A;
                            div     <= inData_B;
                            rem     <= '0;
                            cnt     <= '0;
                            outBusy <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    rem <= rem_next;
                    dvd <= dvd_next;
                    cnt <= cnt + 1'b1;
                    if (last_iter) begin
                        outData_Q <= dvd_next[DATA_WIDTH-1:0];
                        outData_R <= rem_next;
                        outValid  <= 1'b1;
                        outBusy   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
